bcd_stopwatch_ctrl: RTL and testbench

Stopwatch controller that sequences a chain of BCD counting digits from push-button style controls. It owns a clock prescaler, a start/pause/clear state machine, ripple-carry enable generation across DIGITS decade digits, and a lap-freeze display latch. It sits between the board buttons (already synchronised) and the 7-segment display driver, and exports packed BCD digits, least significant digit in bits [3:0].

---
 rtl/bcd_stopwatch_ctrl.sv | 121 ++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: stopwatch with prescaler, run/pause/clear FSM, BCD digit chain and lap latch; BCD_SW_WRAP_EN selects wrap at all-9s instead of the OVF stop state
module bcd_stopwatch_ctrl #(
  parameter int DIGITS = 4,
  parameter int PRESCALE = 12000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                frozen,
  output logic                tick,
  output logic                overflow
);
  localparam int W = 4 * DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};
`ifdef BCD_SW_WRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;
`endif
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0] cnt_q, cnt_d, cnt_inc, lap_q, lap_d, disp_q, disp_d;
  logic ss_q, clr_q, lapin_q;
  logic frozen_q, frozen_d, tick_q, tick_d, ovf_q, ovf_d, run_q;
  logic carry, all9, ss_e, clr_e, lap_e;
  assign ss_e = start_stop & ~ss_q;
  assign clr_e = clear & ~clr_q;
  assign lap_e = lap & ~lapin_q;
  assign all9 = cnt_q == ALL9;
  always_comb begin
    cnt_inc = cnt_q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      cnt_inc[4*i +: 4] = carry ? (cnt_q[4*i +: 4] == 4'd9 ? 4'd0 : cnt_q[4*i +: 4] + 4'd1) : cnt_q[4*i +: 4];
      carry = carry & (cnt_q[4*i +: 4] == 4'd9);
    end
  end
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d = cnt_q;
    lap_d = lap_q;
    frozen_d = frozen_q;
    ovf_d = ovf_q;
    tick_d = 1'b0;
    if (tick_q) begin
      ovf_d = ovf_q | all9;
`ifdef BCD_SW_WRAP_EN
      cnt_d = cnt_inc;
`else
      cnt_d = all9 ? cnt_q : cnt_inc;
`endif
    end
    if (state_q == RUN) begin
      presc_d = presc_q == PMAX ? '0 : presc_q + 1'b1;
      tick_d = presc_q == PMAX;
      if (ss_e) begin
        state_d = PAUSE;
        frozen_d = 1'b0;
      end else if (lap_e) begin
        frozen_d = ~frozen_q;
        lap_d = frozen_q ? lap_q : cnt_q;
      end
    end else if (clr_e) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      frozen_d = 1'b0;
    end else if (ss_e && (state_q == IDLE || state_q == PAUSE)) begin
      state_d = RUN;
    end
`ifndef BCD_SW_WRAP_EN
    if (tick_q && all9 && state_d != IDLE) begin
      state_d = OVF;
      frozen_d = 1'b0;
    end
`endif
    disp_d = frozen_d ? lap_d : cnt_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q <= '0;
      lap_q <= '0;
      disp_q <= '0;
      ss_q <= 1'b0;
      clr_q <= 1'b0;
      lapin_q <= 1'b0;
      frozen_q <= 1'b0;
      tick_q <= 1'b0;
      ovf_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
      lap_q <= lap_d;
      disp_q <= disp_d;
      ss_q <= start_stop;
      clr_q <= clear;
      lapin_q <= lap;
      frozen_q <= frozen_d;
      tick_q <= tick_d;
      ovf_q <= ovf_d;
      run_q <= state_d == RUN;
    end
  end
  assign digits = disp_q;
  assign running = run_q;
  assign frozen = frozen_q;
  assign tick = tick_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: directed checks of bcd_stopwatch_ctrl with DIGITS=2, PRESCALE=4
module tb_bcd_stopwatch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic [7:0] digits;
  logic running, frozen, tick, overflow;
  int checks = 0;
  int errors = 0;
  int n, tk;
  always #5 clk = ~clk;
  bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .digits(digits), .running(running), .frozen(frozen), .tick(tick), .overflow(overflow)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick_once(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick && cnt < 20);
    chk("tick_seen", 32'(tick), 32'd1);
    step();
  endtask
  task automatic run_ticks(input int k);
    int c;
    repeat (k) tick_once(c);
  endtask
  task automatic quiet(input int k, output int seen);
    seen = 0;
    repeat (k) begin
      step();
      seen += int'(tick);
    end
  endtask
  initial begin
    step();
    reset = 1'b0;
    chk("rst_digits", 32'(digits), 32'h00);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("start_running", 32'(running), 32'd1);
    tick_once(n);
    chk("first_tick_latency", 32'(n), 32'd4);
    chk("digits_01", 32'(digits), 32'h01);
    run_ticks(8);
    tick_once(n);
    chk("tick_period", 32'(n), 32'd3);
    chk("digits_10", 32'(digits), 32'h10);
    run_ticks(2);
    chk("digits_12", 32'(digits), 32'h12);
    lap = 1'b1; step(); lap = 1'b0;
    chk("lap_frozen", 32'(frozen), 32'd1);
    chk("lap_digits", 32'(digits), 32'h12);
    run_ticks(3);
    chk("lap_hold", 32'(digits), 32'h12);
    chk("lap_still_frozen", 32'(frozen), 32'd1);
    lap = 1'b1; step(); lap = 1'b0;
    chk("unlap_frozen", 32'(frozen), 32'd0);
    chk("unlap_digits", 32'(digits), 32'h15);
    run_ticks(22);
    chk("digits_37", 32'(digits), 32'h37);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("pause_running", 32'(running), 32'd0);
    quiet(20, tk);
    chk("pause_no_tick", 32'(tk), 32'd0);
    chk("pause_digits", 32'(digits), 32'h37);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("resume_running", 32'(running), 32'd1);
    tick_once(n);
    chk("phase_kept", 32'(n), 32'd2);
    chk("digits_38", 32'(digits), 32'h38);
    start_stop = 1'b1; clear = 1'b1; step(); start_stop = 1'b0; clear = 1'b0;
    chk("run_both_running", 32'(running), 32'd0);
    chk("run_both_digits", 32'(digits), 32'h38);
    step();
    start_stop = 1'b1; clear = 1'b1; step(); start_stop = 1'b0; clear = 1'b0;
    chk("pause_both_running", 32'(running), 32'd0);
    chk("pause_both_digits", 32'(digits), 32'h00);
    step();
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("restart_running", 32'(running), 32'd1);
    tick_once(n);
    chk("restart_latency", 32'(n), 32'd4);
    run_ticks(98);
    chk("digits_99", 32'(digits), 32'h99);
    chk("no_overflow_yet", 32'(overflow), 32'd0);
    tick_once(n);
`ifdef BCD_SW_WRAP_EN
    chk("wrap_digits", 32'(digits), 32'h00);
    chk("wrap_overflow", 32'(overflow), 32'd1);
    chk("wrap_running", 32'(running), 32'd1);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("wrap_pause", 32'(running), 32'd0);
    clear = 1'b1; step(); clear = 1'b0;
    chk("wrap_clear_ovf", 32'(overflow), 32'd0);
    chk("wrap_clear_digits", 32'(digits), 32'h00);
`else
    chk("ovf_digits", 32'(digits), 32'h99);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_running", 32'(running), 32'd0);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("ovf_start_ignored", 32'(running), 32'd0);
    quiet(8, tk);
    chk("ovf_no_tick", 32'(tk), 32'd0);
    chk("ovf_digits_held", 32'(digits), 32'h99);
    clear = 1'b1; step(); clear = 1'b0;
    chk("ovf_clear_digits", 32'(digits), 32'h00);
    chk("ovf_clear_overflow", 32'(overflow), 32'd0);
    chk("ovf_clear_running", 32'(running), 32'd0);
`endif
    step();
    start_stop = 1'b1; step(); start_stop = 1'b0;
    run_ticks(2);
    lap = 1'b1; step(); lap = 1'b0;
    chk("pre_reset_frozen", 32'(frozen), 32'd1);
    chk("pre_reset_digits", 32'(digits), 32'h02);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_digits", 32'(digits), 32'h00);
    chk("mid_rst_running", 32'(running), 32'd0);
    chk("mid_rst_frozen", 32'(frozen), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    quiet(12, tk);
    chk("post_rst_no_tick", 32'(tk), 32'd0);
    chk("post_rst_digits", 32'(digits), 32'h00);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("post_rst_running", 32'(running), 32'd1);
    tick_once(n);
    chk("post_rst_latency", 32'(n), 32'd4);
    chk("post_rst_digits_01", 32'(digits), 32'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
